// File: rtl/breakout_pixel_renderer.sv
// Breakout renderer: per-frame snapshot of game state feeding a 2-stage brick/ball/paddle colour pipeline.
// Optional macro BRICK_OUTLINE_EN draws 1-pixel gaps on the left/top edge of every brick.
module breakout_pixel_renderer #(
    parameter int unsigned BRICK_ROWS    = 5,
    parameter int unsigned BRICK_COLS    = 10,
    parameter int unsigned BRICK_WIDTH   = 64,
    parameter int unsigned BRICK_HEIGHT  = 16,
    parameter int unsigned BALL_SIZE     = 6,
    parameter int unsigned PADDLE_WIDTH  = 64,
    parameter int unsigned PADDLE_HEIGHT = 8,
    parameter int unsigned FLASH_FRAMES  = 30
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pix_en,
    input  logic                             active_pixels,
    input  logic [9:0]                       x,
    input  logic [9:0]                       y,
    input  logic [BRICK_ROWS*BRICK_COLS-1:0] brick_state,
    input  logic [9:0]                       ball_x,
    input  logic [9:0]                       ball_y,
    input  logic [9:0]                       paddle_x,
    input  logic [9:0]                       paddle_y,
    input  logic                             win,
    input  logic                             lose,
    output logic [7:0]                       VGA_R,
    output logic [7:0]                       VGA_G,
    output logic [7:0]                       VGA_B,
    output logic                             active_out,
    output logic                             frame_start
);

    localparam int unsigned NBRICKS = BRICK_ROWS * BRICK_COLS;
    localparam int unsigned IDX_W   = (NBRICKS > 1) ? $clog2(NBRICKS) : 1;
    localparam int unsigned COL_W   = $clog2(BRICK_COLS + 1);
    localparam int unsigned ROW_W   = $clog2(BRICK_ROWS + 1);
    localparam int unsigned XOFF_W  = (BRICK_WIDTH > 1) ? $clog2(BRICK_WIDTH) : 1;
    localparam int unsigned YOFF_W  = (BRICK_HEIGHT > 1) ? $clog2(BRICK_HEIGHT) : 1;
    localparam int unsigned FCNT_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int unsigned FIELD_W = BRICK_COLS * BRICK_WIDTH;
    localparam int unsigned FIELD_H = BRICK_ROWS * BRICK_HEIGHT;

    localparam logic [23:0] RGB_BLACK = 24'h000000;
    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_BG    = 24'h001040;

    typedef enum logic [1:0] {ST_PLAY, ST_WIN, ST_LOSE} state_e;

    // 11-bit span test so origin+length never wraps
    function automatic logic span_hit(input logic [9:0] p, input logic [9:0] org, input logic [10:0] len);
        return ({1'b0, p} >= {1'b0, org}) && ({1'b0, p} < ({1'b0, org} + len));
    endfunction

    function automatic logic [23:0] palette(input logic [2:0] r5);
        case (r5)
            3'd0:    return 24'hFF0000;
            3'd1:    return 24'hFF8800;
            3'd2:    return 24'hFFFF00;
            3'd3:    return 24'h00FF00;
            default: return 24'h0088FF;
        endcase
    endfunction

    logic snap_c;
    assign snap_c = pix_en && (x == 10'd0) && (y == 10'd0);

    // Shadow copies; the _d view lets the snapshot pixel itself see the new frame
    logic [NBRICKS-1:0] mask_sh_q, mask_sh_d;
    logic [9:0]         bx_sh_q, bx_sh_d, by_sh_q, by_sh_d;
    logic [9:0]         px_sh_q, px_sh_d, py_sh_q, py_sh_d;
    logic               win_sh_q, win_sh_d, lose_sh_q, lose_sh_d;

    always_comb begin
        mask_sh_d = snap_c ? brick_state : mask_sh_q;
        bx_sh_d   = snap_c ? ball_x      : bx_sh_q;
        by_sh_d   = snap_c ? ball_y      : by_sh_q;
        px_sh_d   = snap_c ? paddle_x    : px_sh_q;
        py_sh_d   = snap_c ? paddle_y    : py_sh_q;
        win_sh_d  = snap_c ? win         : win_sh_q;
        lose_sh_d = snap_c ? lose        : lose_sh_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_sh_q <= '0;
            bx_sh_q   <= '0;
            by_sh_q   <= '0;
            px_sh_q   <= '0;
            py_sh_q   <= '0;
            win_sh_q  <= 1'b0;
            lose_sh_q <= 1'b0;
        end else if (pix_en) begin
            mask_sh_q <= mask_sh_d;
            bx_sh_q   <= bx_sh_d;
            by_sh_q   <= by_sh_d;
            px_sh_q   <= px_sh_d;
            py_sh_q   <= py_sh_d;
            win_sh_q  <= win_sh_d;
            lose_sh_q <= lose_sh_d;
        end
    end

    // Brick grid position tracked incrementally: col/xoff hold the prediction for the next pixel,
    // row/yoff hold the current line and advance when y changes.
    logic [COL_W-1:0]  col_q, col_d, col_cur;
    logic [XOFF_W-1:0] xoff_q, xoff_d, xoff_cur;
    logic [ROW_W-1:0]  row_q, row_cur;
    logic [YOFF_W-1:0] yoff_q, yoff_cur;
    logic [2:0]        r5_q, r5_cur;
    logic [9:0]        y_last_q;

    always_comb begin
        col_cur  = (x == 10'd0) ? '0 : col_q;
        xoff_cur = (x == 10'd0) ? '0 : xoff_q;
        col_d    = col_cur;
        xoff_d   = xoff_cur + XOFF_W'(1);
        if (xoff_cur == XOFF_W'(BRICK_WIDTH - 1)) begin
            xoff_d = '0;
            if (col_cur != COL_W'(BRICK_COLS)) col_d = col_cur + COL_W'(1);
        end
    end

    always_comb begin
        row_cur  = row_q;
        yoff_cur = yoff_q;
        r5_cur   = r5_q;
        if (y == 10'd0) begin
            row_cur  = '0;
            yoff_cur = '0;
            r5_cur   = '0;
        end else if (y != y_last_q) begin
            if (yoff_q == YOFF_W'(BRICK_HEIGHT - 1)) begin
                yoff_cur = '0;
                if (row_q != ROW_W'(BRICK_ROWS)) row_cur = row_q + ROW_W'(1);
                r5_cur = (r5_q == 3'd4) ? 3'd0 : r5_q + 3'd1;
            end else begin
                yoff_cur = yoff_q + YOFF_W'(1);
            end
        end
    end

    logic             in_grid_c, brick_c, ball_c, paddle_c;
    logic [IDX_W-1:0] idx_c;

    always_comb begin
        in_grid_c = (row_cur < ROW_W'(BRICK_ROWS)) && (col_cur < COL_W'(BRICK_COLS))
                 && ({22'd0, x} < 32'(FIELD_W)) && ({22'd0, y} < 32'(FIELD_H));
        idx_c     = in_grid_c ? (IDX_W'(row_cur) * IDX_W'(BRICK_COLS) + IDX_W'(col_cur)) : '0;
`ifdef BRICK_OUTLINE_EN
        brick_c   = in_grid_c && mask_sh_d[idx_c] && (xoff_cur != '0) && (yoff_cur != '0);
`else
        brick_c   = in_grid_c && mask_sh_d[idx_c];
`endif
        ball_c    = span_hit(x, bx_sh_d, 11'(BALL_SIZE)) && span_hit(y, by_sh_d, 11'(BALL_SIZE));
        paddle_c  = span_hit(x, px_sh_d, 11'(PADDLE_WIDTH)) && span_hit(y, py_sh_d, 11'(PADDLE_HEIGHT));
    end

    // Stage 1: hit flags and palette row, plus the grid counters
    logic       s1_active_q, s1_ball_q, s1_paddle_q, s1_brick_q;
    logic [2:0] s1_r5_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            xoff_q      <= '0;
            row_q       <= '0;
            yoff_q      <= '0;
            r5_q        <= '0;
            y_last_q    <= '0;
            s1_active_q <= 1'b0;
            s1_ball_q   <= 1'b0;
            s1_paddle_q <= 1'b0;
            s1_brick_q  <= 1'b0;
            s1_r5_q     <= '0;
        end else if (pix_en) begin
            col_q       <= col_d;
            xoff_q      <= xoff_d;
            row_q       <= row_cur;
            yoff_q      <= yoff_cur;
            r5_q        <= r5_cur;
            y_last_q    <= y;
            s1_active_q <= active_pixels;
            s1_ball_q   <= ball_c;
            s1_paddle_q <= paddle_c;
            s1_brick_q  <= brick_c;
            s1_r5_q     <= r5_cur;
        end
    end

    // Status FSM and flash timer, both stepped once per snapshot
    state_e            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              phase_q, phase_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PLAY;
            fcnt_q  <= '0;
            phase_q <= 1'b1;
        end else if (pix_en) begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (snap_c) begin
            if (win_sh_d)       state_d = ST_WIN;
            else if (lose_sh_d) state_d = ST_LOSE;
            else                state_d = ST_PLAY;
            if (state_d != state_q) begin
                fcnt_d  = '0;
                phase_d = 1'b1;
            end else if (fcnt_q == FCNT_W'(FLASH_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = !phase_q;
            end else begin
                fcnt_d  = fcnt_q + FCNT_W'(1);
            end
        end
    end

    // Stage 2: colour priority
    logic [23:0] status_bg_c, rgb_d, rgb_q;

    always_comb begin
        status_bg_c = RGB_BG;
        if (phase_q && (state_q == ST_WIN))       status_bg_c = 24'h00FF00;
        else if (phase_q && (state_q == ST_LOSE)) status_bg_c = 24'hFF0000;
        rgb_d = status_bg_c;
        if (!s1_active_q)                  rgb_d = RGB_BLACK;
        else if (s1_ball_q || s1_paddle_q) rgb_d = RGB_WHITE;
        else if (s1_brick_q)               rgb_d = palette(s1_r5_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q      <= '0;
            active_out <= 1'b0;
        end else if (pix_en) begin
            rgb_q      <= rgb_d;
            active_out <= s1_active_q;
        end
    end

    // Pulse lasts exactly one clk even if the next clk has no strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_start <= 1'b0;
        else      frame_start <= snap_c;
    end

    assign VGA_R = rgb_q[23:16];
    assign VGA_G = rgb_q[15:8];
    assign VGA_B = rgb_q[7:0];

endmodule

// File: tb/tb_breakout_pixel_renderer.sv
// Directed bench for breakout_pixel_renderer: pixel-vector table plus snapshot, hold, flash and reset sequences.
module tb_breakout_pixel_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        active_pixels;
    logic [9:0]  x, y;
    logic [49:0] brick_state;
    logic [9:0]  ball_x, ball_y, paddle_x, paddle_y;
    logic        win, lose;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        active_out;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    breakout_pixel_renderer #(.FLASH_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .active_pixels(active_pixels),
        .x(x), .y(y), .brick_state(brick_state),
        .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x), .paddle_y(paddle_y),
        .win(win), .lose(lose),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .active_out(active_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [49:0] mask;
        logic [9:0]  bx, by, qx, qy;
        logic        act;
        logic [9:0]  px, py;
        logic [23:0] rgb;
        logic        eact;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [49:0] m, input int bx, input int by, input int qx, input int qy,
                                input logic a, input int px, input int py, input logic [23:0] c, input logic ea);
        vec_t v;
        v.mask = m; v.bx = 10'(bx); v.by = 10'(by); v.qx = 10'(qx); v.qy = 10'(qy);
        v.act = a; v.px = 10'(px); v.py = 10'(py); v.rgb = c; v.eact = ea;
        return v;
    endfunction

    task automatic chk_rgb(input string name, input logic [23:0] want);
        n_cmp++;
        if ({VGA_R, VGA_G, VGA_B} !== want) begin
            n_bad++;
            $display("FAIL %s: rgb=%06h expected %06h", name, {VGA_R, VGA_G, VGA_B}, want);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, got, want);
        end
    endtask

    // One pix_en strobe; returns 1 time unit after the capturing edge
    task automatic strobe(input logic [9:0] sx, input logic [9:0] sy);
        x = sx; y = sy; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
    endtask

    // Continue a frame from the snapshot to (px,py), then one more strobe so (px,py) reaches the output
    task automatic walk_to(input int px, input int py);
        for (int yy = 1; yy <= py; yy++) strobe(10'd0, 10'(yy));
        for (int xx = 1; xx <= px; xx++) strobe(10'(xx), 10'(py));
        strobe(10'(px + 1), 10'(py));
    endtask

    task automatic frame_to(input int px, input int py);
        strobe(10'd0, 10'd0);
        walk_to(px, py);
    endtask

    // A line walk that never passes (0,0), so no snapshot is taken
    task automatic line_no_snap(input int px, input int py);
        for (int xx = 0; xx <= px + 1; xx++) strobe(10'(xx), 10'(py));
    endtask

    logic [49:0] all1, only11, no11;
    logic [23:0] flash_exp [5];

    initial begin
        all1   = {50{1'b1}};
        only11 = 50'd1 << 11;
        no11   = all1 & ~only11;

        vecs[0]  = mk(all1,   900, 400, 900, 450, 1'b1,   70,  20, 24'hFF8800, 1'b1);
        vecs[1]  = mk(all1,   900, 400, 900, 450, 1'b1,    5,   3, 24'hFF0000, 1'b1);
        vecs[2]  = mk(all1,   900, 400, 900, 450, 1'b1,  200,  40, 24'hFFFF00, 1'b1);
        vecs[3]  = mk(all1,   900, 400, 900, 450, 1'b1,  300,  50, 24'h00FF00, 1'b1);
        vecs[4]  = mk(all1,   900, 400, 900, 450, 1'b1,  639,  79, 24'h0088FF, 1'b1);
        vecs[5]  = mk(all1,   900, 400, 900, 450, 1'b1,  640,  79, 24'h001040, 1'b1);
        vecs[6]  = mk(all1,   900, 400, 900, 450, 1'b1,  100,  80, 24'h001040, 1'b1);
        vecs[7]  = mk(no11,   900, 400, 900, 450, 1'b1,   70,  20, 24'h001040, 1'b1);
        vecs[8]  = mk(only11, 900, 400, 900, 450, 1'b1,   64,  16, 24'hFF8800, 1'b1);
        vecs[9]  = mk(only11, 900, 400, 900, 450, 1'b1,   63,  16, 24'h001040, 1'b1);
        vecs[10] = mk(only11, 900, 400, 900, 450, 1'b1,  127,  31, 24'hFF8800, 1'b1);
        vecs[11] = mk(only11, 900, 400, 900, 450, 1'b1,  128,  31, 24'h001040, 1'b1);
        vecs[12] = mk(only11, 900, 400, 900, 450, 1'b1,  127,  32, 24'h001040, 1'b1);
        vecs[13] = mk(all1,   900, 400, 900, 450, 1'b0,   70,  20, 24'h000000, 1'b0);
        vecs[14] = mk(all1,   100, 100,  98,  98, 1'b1,  101, 101, 24'hFFFFFF, 1'b1);
        vecs[15] = mk(all1,   100, 100,  98,  98, 1'b1,  106, 101, 24'hFFFFFF, 1'b1);
        vecs[16] = mk(all1,   100, 100,  98,  98, 1'b1,  162, 101, 24'h001040, 1'b1);
        vecs[17] = mk(all1,   200, 200, 900, 450, 1'b1,  205, 205, 24'hFFFFFF, 1'b1);
        vecs[18] = mk(all1,   200, 200, 900, 450, 1'b1,  206, 205, 24'h001040, 1'b1);
        vecs[19] = mk(all1,    60,  10, 900, 450, 1'b1,   62,  12, 24'hFFFFFF, 1'b1);
        vecs[20] = mk(50'd0, 1020,   8, 900, 450, 1'b1, 1021,  10, 24'hFFFFFF, 1'b1);
        vecs[21] = mk(all1,   900, 400,   0, 100, 1'b1,   63, 107, 24'hFFFFFF, 1'b1);
        vecs[22] = mk(all1,   900, 400,   0, 100, 1'b1,   64, 107, 24'h001040, 1'b1);

        flash_exp[0] = 24'h00FF00; flash_exp[1] = 24'h00FF00;
        flash_exp[2] = 24'h001040; flash_exp[3] = 24'h001040;
        flash_exp[4] = 24'h00FF00;

        // Reset state, with a would-be snapshot strobe held off by reset
        rst = 1'b0; pix_en = 1'b0; active_pixels = 1'b1; x = '0; y = '0;
        brick_state = all1; ball_x = 10'd900; ball_y = 10'd400; paddle_x = 10'd900; paddle_y = 10'd450;
        win = 1'b0; lose = 1'b0;
        repeat (2) @(posedge clk);
        pix_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_rgb("reset rgb", 24'h000000);
        chk_bit("reset active_out", active_out, 1'b0);
        chk_bit("reset frame_start", frame_start, 1'b0);
        pix_en = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Mid-frame start after reset: shadow mask is still empty
        line_no_snap(70, 20);
        chk_rgb("post-reset no bricks", 24'h001040);
        frame_to(70, 20);
        chk_rgb("post-reset after snapshot", 24'hFF8800);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            brick_state = vecs[i].mask;
            ball_x = vecs[i].bx; ball_y = vecs[i].by;
            paddle_x = vecs[i].qx; paddle_y = vecs[i].qy;
            active_pixels = vecs[i].act;
            frame_to(int'(vecs[i].px), int'(vecs[i].py));
            chk_rgb($sformatf("vec%0d rgb", i), vecs[i].rgb);
            chk_bit($sformatf("vec%0d active_out", i), active_out, vecs[i].eact);
        end
        active_pixels = 1'b1; ball_x = 10'd900; ball_y = 10'd400; paddle_x = 10'd900; paddle_y = 10'd450;

        // Mid-frame mask change is deferred to the next frame
        brick_state = all1;
        strobe(10'd0, 10'd0);
        chk_bit("frame_start pulse", frame_start, 1'b1);
        brick_state = no11;
        walk_to(70, 20);
        chk_rgb("deferred mask this frame", 24'hFF8800);
        chk_bit("frame_start cleared", frame_start, 1'b0);
        frame_to(70, 20);
        chk_rgb("deferred mask next frame", 24'h001040);

        // pix_en low for 5 clks: outputs and counters hold
        brick_state = only11;
        frame_to(125, 20);
        chk_rgb("hold pre", 24'hFF8800);
        active_pixels = 1'b0; brick_state = '0;
        repeat (5) begin
            x = 10'($urandom_range(0, 1023)); y = 10'($urandom_range(0, 1023));
            @(posedge clk); #1;
        end
        chk_rgb("hold rgb", 24'hFF8800);
        chk_bit("hold active_out", active_out, 1'b1);
        chk_bit("hold frame_start", frame_start, 1'b0);
        active_pixels = 1'b1;
        strobe(10'd127, 10'd20);
        chk_rgb("hold resume x126", 24'hFF8800);
        strobe(10'd128, 10'd20);
        chk_rgb("hold resume x127", 24'hFF8800);
        strobe(10'd129, 10'd20);
        chk_rgb("hold resume x128", 24'h001040);

        // Win and lose together: WIN flashes 2 frames on, 2 off
        brick_state = '0; win = 1'b1; lose = 1'b1;
        for (int f = 0; f < 5; f++) begin
            frame_to(10, 1);
            chk_rgb($sformatf("win flash frame%0d", f), flash_exp[f]);
        end
        win = 1'b0;
        frame_to(10, 1);
        chk_rgb("lose frame0", 24'hFF0000);
        win = 1'b1;
        walk_to(20, 2);
        chk_rgb("win change mid-frame ignored", 24'hFF0000);
        win = 1'b0;
        frame_to(10, 1);
        chk_rgb("lose frame1", 24'hFF0000);
        lose = 1'b0;
        frame_to(10, 1);
        chk_rgb("back to play", 24'h001040);

        // Asynchronous reset mid-line
        brick_state = all1;
        frame_to(70, 20);
        chk_rgb("pre-reset pixel", 24'hFF8800);
        strobe(10'd0, 10'd0);
        chk_bit("pre-reset frame_start", frame_start, 1'b1);
        chk_rgb("pre-reset rgb x71", 24'hFF8800);
        #2 rst = 1'b0;
        #1;
        chk_rgb("async reset rgb", 24'h000000);
        chk_bit("async reset frame_start", frame_start, 1'b0);
        chk_bit("async reset active_out", active_out, 1'b0);
        @(negedge clk); rst = 1'b1;
        line_no_snap(70, 20);
        chk_rgb("after reset bricks absent", 24'h001040);
        frame_to(70, 20);
        chk_rgb("after reset snapshot", 24'hFF8800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
